// File: rtl/dmem_if.sv
// Load/store request and response bus between the pipeline and the
// data-memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory that answers one load/store at a time
// after a fixed number of wait cycles.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int LATENCY     = 2,
  parameter int INIT_OFFSET = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_if.slave       bus,
  output logic [15:0] txn_count
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LM1 = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] txn_q, txn_d;
  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          done;
  logic          enter_resp;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          c_inr;
  logic [AW-1:0] c_idx;
  logic          wr_en;

  // State, wait counter, captured request and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
    end
  end

  // Memory array: reset pattern, store commit on entry to RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'(i + INIT_OFFSET);
      end
    end else if (wr_en) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  // Next-state logic and wait counter sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    accept     = (state_q == IDLE) && bus.req_valid;
    done       = (state_q == RESP) && bus.resp_ready;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LM1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, memory access and response data
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      we_d    = bus.req_we;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end
    // zero-latency builds enter RESP on the accept edge itself
    if (state_q == IDLE) begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
    c_inr   = c_addr < 32'(DEPTH);
    c_idx   = c_addr[AW-1:0];
    wr_en   = enter_resp && c_we && c_inr;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = !c_inr;
      rdata_d = (!c_we && c_inr) ? mem_q[c_idx] : 32'd0;
    end
    txn_d = done ? txn_q + 16'd1 : txn_q;
  end

  // Bus outputs decoded from state and response registers
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    txn_count      = txn_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a
// LATENCY=0 instance driven from one linear stimulus sequence.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [15:0] tm;
  logic [15:0] tz;
  int          checks;
  int          errors;

  dmem_if ifm ();
  dmem_if if0 ();

  dmem_responder #(.DEPTH(64), .LATENCY(2), .INIT_OFFSET(2)) dut_m (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifm.slave),
    .txn_count (tm)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0), .INIT_OFFSET(2)) dut_z (
    .clk       (clk),
    .reset     (reset),
    .bus       (if0.slave),
    .txn_count (tz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit z, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er,
                     output int n);
    if (z) begin
      if0.req_valid = 1'b1;
      if0.req_we    = we;
      if0.req_addr  = addr;
      if0.req_wdata = wd;
    end else begin
      ifm.req_valid = 1'b1;
      ifm.req_we    = we;
      ifm.req_addr  = addr;
      ifm.req_wdata = wd;
    end
    @(posedge clk); #1;
    if0.req_valid = 1'b0;
    ifm.req_valid = 1'b0;
    n = 1;
    while (!(z ? if0.resp_valid : ifm.resp_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    rd = z ? if0.resp_rdata : ifm.resp_rdata;
    er = z ? if0.resp_err : ifm.resp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          n;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    ifm.req_valid = 1'b0; ifm.req_we = 1'b0;
    ifm.req_addr  = '0;   ifm.req_wdata = '0;
    ifm.resp_ready = 1'b1;
    if0.req_valid = 1'b0; if0.req_we = 1'b0;
    if0.req_addr  = '0;   if0.req_wdata = '0;
    if0.resp_ready = 1'b1;

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(ifm.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(ifm.resp_valid), 32'd0);
    chk("rst_rdata", ifm.resp_rdata, 32'd0);
    chk("rst_err", 32'(ifm.resp_err), 32'd0);
    chk("rst_txn", 32'(tm), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // loads of the reset pattern
    for (int i = 0; i < 5; i++) begin
      chk("ld_ready", 32'(ifm.req_ready), 32'd1);
      txn(1'b0, 1'b0, 32'(i), 32'd0, rd, er, n);
      chk("ld_rdata", rd, 32'(i + 2));
      chk("ld_err", 32'(er), 32'd0);
      chk("ld_lat", 32'(n), 32'd3);
    end
    chk("ld_txn", 32'(tm), 32'd5);

    // store then load back
    txn(1'b0, 1'b1, 32'd7, 32'hDEADBEEF, rd, er, n);
    chk("st7_rdata", rd, 32'd0);
    chk("st7_err", 32'(er), 32'd0);
    txn(1'b0, 1'b0, 32'd7, 32'd0, rd, er, n);
    chk("ld7_rdata", rd, 32'hDEADBEEF);
    chk("ld7_err", 32'(er), 32'd0);

    // out of range
    txn(1'b0, 1'b0, 32'd64, 32'd0, rd, er, n);
    chk("ld64_err", 32'(er), 32'd1);
    chk("ld64_rdata", rd, 32'd0);
    txn(1'b0, 1'b1, 32'd100, 32'h12345678, rd, er, n);
    chk("st100_err", 32'(er), 32'd1);
    chk("st100_rdata", rd, 32'd0);
    chk("st100_lat", 32'(n), 32'd3);
    txn(1'b0, 1'b0, 32'd63, 32'd0, rd, er, n);
    chk("ld63_rdata", rd, 32'd65);
    chk("ld63_err", 32'(er), 32'd0);
    chk("oor_txn", 32'(tm), 32'd10);

    // response backpressure with a competing request held on the bus
    ifm.resp_ready = 1'b0;
    ifm.req_valid = 1'b1; ifm.req_we = 1'b0; ifm.req_addr = 32'd2;
    @(posedge clk); #1;
    ifm.req_we = 1'b1; ifm.req_addr = 32'd2; ifm.req_wdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stall_valid_rise", 32'(ifm.resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(ifm.resp_valid), 32'd1);
      chk("stall_rdata", ifm.resp_rdata, 32'd4);
      chk("stall_ready", 32'(ifm.req_ready), 32'd0);
      chk("stall_txn", 32'(tm), 32'd10);
      @(posedge clk); #1;
    end
    ifm.req_valid  = 1'b0;
    ifm.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_done_valid", 32'(ifm.resp_valid), 32'd0);
    chk("stall_done_ready", 32'(ifm.req_ready), 32'd1);
    chk("stall_done_txn", 32'(tm), 32'd11);
    txn(1'b0, 1'b0, 32'd2, 32'd0, rd, er, n);
    chk("stall_no_write", rd, 32'd4);

    // reset during WAIT aborts the store
    ifm.req_valid = 1'b1; ifm.req_we = 1'b1;
    ifm.req_addr = 32'd3; ifm.req_wdata = 32'h55;
    @(posedge clk); #1;
    ifm.req_valid = 1'b0;
    chk("abort_in_wait", 32'(ifm.req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_valid", 32'(ifm.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("abort_txn", 32'(tm), 32'd0);
    txn(1'b0, 1'b0, 32'd3, 32'd0, rd, er, n);
    chk("abort_ld3", rd, 32'd5);
    txn(1'b0, 1'b0, 32'd7, 32'd0, rd, er, n);
    chk("reinit_ld7", rd, 32'd9);
    chk("abort_txn2", 32'(tm), 32'd2);

    // zero-latency instance
    txn(1'b1, 1'b0, 32'd5, 32'd0, rd, er, n);
    chk("z_ld5", rd, 32'd7);
    chk("z_lat", 32'(n), 32'd1);
    txn(1'b1, 1'b1, 32'd5, 32'h1234, rd, er, n);
    chk("z_st5_rdata", rd, 32'd0);
    chk("z_st_lat", 32'(n), 32'd1);
    txn(1'b1, 1'b0, 32'd5, 32'd0, rd, er, n);
    chk("z_ld5b", rd, 32'h1234);
    txn(1'b1, 1'b0, 32'd64, 32'd0, rd, er, n);
    chk("z_oor_err", 32'(er), 32'd1);
    chk("z_txn", 32'(tz), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit data words held.
REQ-002 Parameter LATENCY, default 2, wait cycles between request accept and response (legal 0..15).
REQ-003 Parameter INIT_OFFSET, default 2, reset content rule: mem[i] = i + INIT_OFFSET.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (reset=0 sampled at a rising edge resets the block).
REQ-006 req_valid  input  1  pipeline presents a load/store request.
REQ-007 req_we  input  1  1 = store (SW), 0 = load (LW).
REQ-008 req_addr  input  32  word address (not byte address).
REQ-009 req_wdata  input  32  store data.
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  pipeline accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  address out of range (req_addr >= DEPTH).
REQ-015 txn_count  output  16  number of completed response handshakes.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-017 Accept = req_valid & req_ready at a rising edge; at accept, we/addr/wdata SHALL be captured and req_* ignored until the next IDLE.
REQ-018 IDLE->WAIT on accept when LATENCY>0 (wait counter loaded with LATENCY-1); IDLE->RESP on accept when LATENCY=0.
REQ-019 WAIT decrements each cycle; WAIT->RESP on the edge where counter = 0.
REQ-020 resp_valid SHALL rise exactly LATENCY+1 edges after the accept edge.
REQ-021 Store commit and load read SHALL occur on the edge entering RESP; a load of an address stored by an earlier transaction returns the stored value.
REQ-022 resp_rdata, resp_err SHALL be held stable while resp_valid=1 and resp_ready=0.
REQ-023 RESP->IDLE on resp_valid & resp_ready; txn_count increments on that edge, wrapping 0xFFFF->0x0000.
REQ-024 Out-of-range request: resp_err=1, resp_rdata=0, no memory write; handshake otherwise identical.
REQ-025 Store response: resp_rdata=0, resp_err reflects range only.
REQ-026 Only the low 32 bits of req_addr compared against DEPTH; no aliasing/wrap of out-of-range addresses.
REQ-027 Max throughput: one transaction per LATENCY+2 cycles (no accept in the cycle the response completes).

Reset
REQ-028 On reset=0 at an edge: state IDLE, wait counter 0, req_ready=1 on the following cycle, resp_valid=0, resp_rdata=0, resp_err=0, txn_count=0, mem[i]=i+INIT_OFFSET for all i.
REQ-029 Reset during WAIT or RESP SHALL abort the transaction with no write and no txn_count increment.
REQ-030 reset has priority over every other event in the same cycle.

Verification
REQ-031 Reset, then loads addr 0..4 with resp_ready=1 -> rdata 2,3,4,5,6; each resp_valid 3 edges after accept; txn_count=5.
REQ-032 Store addr 7 wdata 0xDEADBEEF, then load addr 7 -> store resp_rdata=0, load resp_rdata=0xDEADBEEF, resp_err=0.
REQ-033 Load addr 64 (DEPTH=64) and store addr 100 -> resp_err=1, rdata=0; subsequent load addr 63 returns 65 (unchanged).
REQ-034 resp_ready held 0 for 5 cycles in RESP -> resp_valid, rdata stay constant, req_ready=0, txn_count unchanged until handshake.
REQ-035 Store addr 3 wdata 0x55, reset=0 during WAIT -> resp_valid never rises, later load addr 3 returns 5, txn_count=0; LATENCY=0 build: accept->resp_valid next cycle.
